// File: rtl/pf_iod_tx_lane_ctrl.sv
// pf_iod_tx_lane_ctrl
// Fabric-side controller for a group of output-only DDR PHY IODs.
// - Registers per-lane TX data / OE phases (1-cycle latency).
// - Runs a command-driven delay-line sequencer: DIRECTION setup, spaced
//   MOVE pulses with settle time, LOAD pulses, early stop on out-of-range.
// Optional: define PF_IOD_TAP_TRACK_EN to add the TAP_POS port, which
// tracks a saturating relative tap position per lane.
//
// state | meaning
// IDLE  | ready for a command
// SETUP | direction bit driven to target lane before first MOVE
// PULSE | one MOVE pulse on the target lane
// WAIT  | settle time after a MOVE/LOAD pulse, out-of-range sampled at end
// LOADP | one LOAD pulse on the target lane
// FIN   | one-cycle DONE, direction released on exit
module pf_iod_tx_lane_ctrl #(
  parameter int LANES  = 8,
  parameter int RATIO  = 4,
  parameter int STEP_W = 8,
  parameter int SETTLE = 2,
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                      FAB_CLK,
  input  logic                      TX_SYNC_RST,
  input  logic [LANES*RATIO-1:0]    TX_DATA_IN,
  input  logic [LANES*RATIO-1:0]    OE_IN,
  output logic [LANES*RATIO-1:0]    TX_DATA_0,
  output logic [LANES*RATIO-1:0]    OE_DATA_0,
  input  logic                      CMD_VALID,
  output logic                      CMD_READY,
  input  logic                      CMD_OP,
  input  logic [LW-1:0]             CMD_LANE,
  input  logic                      CMD_DIR,
  input  logic [STEP_W-1:0]         CMD_STEPS,
  output logic [LANES-1:0]          DELAY_LINE_MOVE_0,
  output logic [LANES-1:0]          DELAY_LINE_DIRECTION_0,
  output logic [LANES-1:0]          DELAY_LINE_LOAD_0,
  input  logic [LANES-1:0]          DELAY_LINE_OUT_OF_RANGE_0,
  output logic                      DONE,
  output logic                      ERR,
  output logic [STEP_W-1:0]         STEPS_DONE
`ifdef PF_IOD_TAP_TRACK_EN
  ,
  output logic [LANES*8-1:0]        TAP_POS
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_PULSE, S_WAIT, S_LOADP, S_FIN
  } state_e;

  state_e              state_q;
  logic                ready_q, done_q, err_q, op_q;
  logic [LW-1:0]       lane_q;
  logic [STEP_W-1:0]   steps_q, steps_done_q;
  logic [3:0]          wait_q;
  logic [LANES-1:0]    move_q, dir_q, load_q;
  logic [LANES*RATIO-1:0] tx_q, oe_q;

  function automatic logic [LANES-1:0] lane_bit(input logic [LW-1:0] l);
    logic [LANES-1:0] b;
    b    = '0;
    b[l] = 1'b1;
    return b;
  endfunction

  // Datapath: register fabric data and OE phases towards the IODs
  always_ff @(posedge FAB_CLK) begin
    if (TX_SYNC_RST) begin
      tx_q <= '0;
      oe_q <= '0;
    end else begin
      tx_q <= TX_DATA_IN;
      oe_q <= OE_IN;
    end
  end

  // Sequencer FSM; every IOD-facing output is registered and set on state entry
  always_ff @(posedge FAB_CLK) begin
    if (TX_SYNC_RST) begin
      state_q      <= S_IDLE;
      ready_q      <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      op_q         <= 1'b0;
      lane_q       <= '0;
      steps_q      <= '0;
      steps_done_q <= '0;
      wait_q       <= '0;
      move_q       <= '0;
      dir_q        <= '0;
      load_q       <= '0;
    end else begin
      done_q <= 1'b0;
      move_q <= '0;
      load_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (CMD_VALID) begin
            ready_q      <= 1'b0;
            err_q        <= 1'b0;
            steps_done_q <= '0;
            op_q         <= CMD_OP;
            lane_q       <= CMD_LANE;
            steps_q      <= CMD_STEPS;
            if (int'(CMD_LANE) >= LANES) begin
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_FIN;
            end else if (CMD_OP) begin
              load_q  <= lane_bit(CMD_LANE);
              state_q <= S_LOADP;
            end else if (CMD_STEPS == '0) begin
              done_q  <= 1'b1;
              state_q <= S_FIN;
            end else begin
              dir_q   <= CMD_DIR ? lane_bit(CMD_LANE) : '0;
              state_q <= S_SETUP;
            end
          end
        end
        S_SETUP: begin
          move_q       <= lane_bit(lane_q);
          steps_done_q <= steps_done_q + 1'b1;
          state_q      <= S_PULSE;
        end
        S_PULSE, S_LOADP: begin
          wait_q  <= 4'(SETTLE - 1);
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_q != '0) begin
            wait_q <= wait_q - 1'b1;
          end else if (op_q) begin
            // out-of-range is meaningless right after a LOAD
            done_q  <= 1'b1;
            state_q <= S_FIN;
          end else if (DELAY_LINE_OUT_OF_RANGE_0[lane_q]) begin
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= S_FIN;
          end else if (steps_done_q == steps_q) begin
            done_q  <= 1'b1;
            state_q <= S_FIN;
          end else begin
            move_q       <= lane_bit(lane_q);
            steps_done_q <= steps_done_q + 1'b1;
            state_q      <= S_PULSE;
          end
        end
        S_FIN: begin
          dir_q   <= '0;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          dir_q   <= '0;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign TX_DATA_0              = tx_q;
  assign OE_DATA_0              = oe_q;
  assign CMD_READY              = ready_q;
  assign DONE                   = done_q;
  assign ERR                    = err_q;
  assign STEPS_DONE             = steps_done_q;
  assign DELAY_LINE_MOVE_0      = move_q;
  assign DELAY_LINE_DIRECTION_0 = dir_q;
  assign DELAY_LINE_LOAD_0      = load_q;

`ifdef PF_IOD_TAP_TRACK_EN
  logic [LANES*8-1:0] tap_q;

  // Per-lane saturating tap tracker: follows each MOVE, cleared by LOAD
  always_ff @(posedge FAB_CLK) begin
    if (TX_SYNC_RST) begin
      tap_q <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (LW'(i) == lane_q) begin
          if (state_q == S_PULSE) begin
            if (dir_q[i] && tap_q[i*8 +: 8] != 8'hFF)
              tap_q[i*8 +: 8] <= tap_q[i*8 +: 8] + 8'd1;
            else if (!dir_q[i] && tap_q[i*8 +: 8] != 8'h00)
              tap_q[i*8 +: 8] <= tap_q[i*8 +: 8] - 8'd1;
          end else if (state_q == S_LOADP) begin
            tap_q[i*8 +: 8] <= 8'h00;
          end
        end
      end
    end
  end

  assign TAP_POS = tap_q;
`endif

endmodule

// File: tb/tb_pf_iod_tx_lane_ctrl.sv
// Self-checking bench for pf_iod_tx_lane_ctrl (LANES=3 so a bad lane index is reachable).
module tb_pf_iod_tx_lane_ctrl;
  localparam int LANES  = 3;
  localparam int RATIO  = 4;
  localparam int STEP_W = 8;
  localparam int SETTLE = 2;
  localparam int LW     = 2;
  localparam int DW     = LANES * RATIO;
  localparam int PER    = 1 + SETTLE;

  logic              FAB_CLK = 1'b0;
  logic              TX_SYNC_RST;
  logic [DW-1:0]     TX_DATA_IN, OE_IN, TX_DATA_0, OE_DATA_0;
  logic              CMD_VALID, CMD_READY, CMD_OP, CMD_DIR;
  logic [LW-1:0]     CMD_LANE;
  logic [STEP_W-1:0] CMD_STEPS, STEPS_DONE;
  logic [LANES-1:0]  MOVE, DIRN, LOAD, OOR;
  logic              DONE, ERR;
`ifdef PF_IOD_TAP_TRACK_EN
  logic [LANES*8-1:0] TAP_POS;
`endif

  always #5 FAB_CLK = ~FAB_CLK;

  pf_iod_tx_lane_ctrl #(.LANES(LANES), .RATIO(RATIO), .STEP_W(STEP_W), .SETTLE(SETTLE)) dut (
    .FAB_CLK(FAB_CLK), .TX_SYNC_RST(TX_SYNC_RST),
    .TX_DATA_IN(TX_DATA_IN), .OE_IN(OE_IN), .TX_DATA_0(TX_DATA_0), .OE_DATA_0(OE_DATA_0),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_OP(CMD_OP), .CMD_LANE(CMD_LANE),
    .CMD_DIR(CMD_DIR), .CMD_STEPS(CMD_STEPS),
    .DELAY_LINE_MOVE_0(MOVE), .DELAY_LINE_DIRECTION_0(DIRN), .DELAY_LINE_LOAD_0(LOAD),
    .DELAY_LINE_OUT_OF_RANGE_0(OOR), .DONE(DONE), .ERR(ERR), .STEPS_DONE(STEPS_DONE)
`ifdef PF_IOD_TAP_TRACK_EN
    , .TAP_POS(TAP_POS)
`endif
  );

  int checks = 0;
  int errors = 0;
  int tap_m[LANES];

  typedef struct {
    logic op;
    int   lane;
    logic dir;
    int   steps;
    int   oor_p;     // OOR on target lane rises after this pulse number (0 = never)
    int   exp_done;  // DONE cycle, accept = cycle 0
    logic exp_err;
    int   exp_sd;
    int   exp_tap;   // target-lane tap afterwards, -1 = not applicable
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // one clock; checks the 1-cycle registered datapath against what was driven
  task automatic step();
    logic [DW-1:0] et, eo;
    et = TX_SYNC_RST ? '0 : TX_DATA_IN;
    eo = TX_SYNC_RST ? '0 : OE_IN;
    @(posedge FAB_CLK);
    #1;
    chk("tx_data", TX_DATA_0, et);
    chk("oe_data", OE_DATA_0, eo);
  endtask

  task automatic rand_data();
    TX_DATA_IN = DW'($urandom);
    OE_IN      = DW'($urandom);
  endtask

  task automatic check_taps();
`ifdef PF_IOD_TAP_TRACK_EN
    for (int i = 0; i < LANES; i++)
      chk("tap_pos", TAP_POS[i*8 +: 8], tap_m[i]);
`endif
  endtask

  task automatic run_cmd(input logic op, input int lane, input logic dir, input int steps,
                         input int oor_p, output int obs_done, output logic obs_err,
                         output int obs_sd);
    logic             valid, exp_err;
    logic [LANES-1:0] oh;
    int               n, exp_done;
    valid = (lane < LANES);
    oh    = valid ? (LANES'(1) << lane) : '0;
    n     = 0;
    if (!valid) begin
      exp_done = 1; exp_err = 1'b1;
    end else if (op) begin
      exp_done = 2 + SETTLE; exp_err = 1'b0;
    end else if (steps == 0) begin
      exp_done = 1; exp_err = 1'b0;
    end else begin
      if (oor_p > 0 && oor_p <= steps) begin
        n = oor_p; exp_err = 1'b1;
      end else begin
        n = steps; exp_err = 1'b0;
      end
      exp_done = 2 + n * PER;
    end

    chk("ready_idle", CMD_READY, 1);
    CMD_VALID = 1'b1;
    CMD_OP    = op;
    CMD_LANE  = LW'(lane);
    CMD_DIR   = dir;
    CMD_STEPS = STEP_W'(steps);
    OOR       = LANES'($urandom) & ~oh;
    rand_data();
    step();
    obs_done = 0;
    for (int c = 1; c <= exp_done + 1; c++) begin
      logic [LANES-1:0] em, ed, el, o;
      em = (c >= 2 && (c - 2) % PER == 0 && (c - 2) / PER < n) ? oh : '0;
      el = (valid && op && c == 1) ? oh : '0;
      ed = (valid && !op && steps > 0 && dir && c <= exp_done) ? oh : '0;
      chk("lane_pulses", {MOVE, DIRN, LOAD}, {em, ed, el});
      chk("done_ready", {DONE, CMD_READY}, {(c == exp_done), (c == exp_done + 1)});
      if (DONE && obs_done == 0) obs_done = c;
      o = LANES'($urandom) & ~oh;
      if (valid && !op && oor_p > 0 && c > 2 + (oor_p - 1) * PER) o = o | oh;
      if (valid && op && c >= 2) o = o | oh;
      OOR       = o;
      // command inputs must be ignored while busy
      CMD_VALID = (c <= exp_done) ? 1'($urandom) : 1'b0;
      CMD_OP    = 1'($urandom);
      CMD_LANE  = LW'($urandom);
      CMD_DIR   = 1'($urandom);
      CMD_STEPS = STEP_W'($urandom);
      rand_data();
      step();
    end
    obs_err = ERR;
    obs_sd  = int'(STEPS_DONE);
    chk("done_cycle", obs_done, exp_done);
    chk("err", obs_err, exp_err);
    chk("steps_done", obs_sd, n);
    if (valid) begin
      if (op) tap_m[lane] = 0;
      for (int k = 0; k < n; k++)
        tap_m[lane] = dir ? ((tap_m[lane] < 255) ? tap_m[lane] + 1 : 255)
                          : ((tap_m[lane] > 0) ? tap_m[lane] - 1 : 0);
    end
    check_taps();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   od, osd;
    logic oe;

    //        op    lane dir   steps oor done err   sd  tap
    tbl[0] = '{1'b0, 1, 1'b1, 3,   0, 11,  1'b0, 3,   3};
    tbl[1] = '{1'b0, 0, 1'b1, 10,  2, 8,   1'b1, 2,   2};
    tbl[2] = '{1'b1, 1, 1'b0, 0,   0, 4,   1'b0, 0,   0};
    tbl[3] = '{1'b0, 3, 1'b1, 4,   0, 1,   1'b1, 0,  -1};
    tbl[4] = '{1'b0, 2, 1'b1, 0,   0, 1,   1'b0, 0,   0};
    tbl[5] = '{1'b0, 2, 1'b0, 1,   0, 5,   1'b0, 1,   0};
    tbl[6] = '{1'b0, 0, 1'b1, 1,   1, 5,   1'b1, 1,   3};
    tbl[7] = '{1'b0, 1, 1'b1, 255, 0, 767, 1'b0, 255, 255};

    for (int i = 0; i < LANES; i++) tap_m[i] = 0;
    TX_SYNC_RST = 1'b1;
    TX_DATA_IN  = '0;
    OE_IN       = '0;
    CMD_VALID   = 1'b0;
    CMD_OP      = 1'b0;
    CMD_LANE    = '0;
    CMD_DIR     = 1'b0;
    CMD_STEPS   = '0;
    OOR         = '0;
    step();
    step();
    chk("reset_outputs", {MOVE, DIRN, LOAD, DONE, ERR, STEPS_DONE}, 0);
    chk("reset_ready", CMD_READY, 1);
    check_taps();

    TX_SYNC_RST = 1'b0;
    TX_DATA_IN  = DW'(12'h0A5);
    step();
    chk("data_a5", TX_DATA_0, DW'(12'h0A5));
    TX_SYNC_RST = 1'b1;
    step();
    chk("data_rst", TX_DATA_0, 0);
    chk("ready_rst", CMD_READY, 1);
    TX_SYNC_RST = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_cmd(tbl[i].op, tbl[i].lane, tbl[i].dir, tbl[i].steps, tbl[i].oor_p, od, oe, osd);
      chk("tbl_done", od, tbl[i].exp_done);
      chk("tbl_err", oe, tbl[i].exp_err);
      chk("tbl_sd", osd, tbl[i].exp_sd);
`ifdef PF_IOD_TAP_TRACK_EN
      if (tbl[i].exp_tap >= 0)
        chk("tbl_tap", TAP_POS[tbl[i].lane*8 +: 8], tbl[i].exp_tap);
`endif
    end

    // reset in cycle 4 of a 5-step MOVE
    chk("ready_pre_rst", CMD_READY, 1);
    CMD_VALID = 1'b1; CMD_OP = 1'b0; CMD_LANE = 2'd2; CMD_DIR = 1'b1; CMD_STEPS = 8'd5;
    OOR = '0;
    step();
    CMD_VALID = 1'b0;
    step();
    chk("mid_move_pulse", MOVE, 3'b100);
    step();
    step();
    TX_SYNC_RST = 1'b1;
    TX_DATA_IN  = '1;
    step();
    TX_SYNC_RST = 1'b0;
    chk("midrst_outputs", {MOVE, DIRN, LOAD, DONE, ERR, STEPS_DONE}, 0);
    chk("midrst_ready", CMD_READY, 1);
    for (int i = 0; i < LANES; i++) tap_m[i] = 0;
    check_taps();
    for (int i = 0; i < 12; i++) begin
      rand_data();
      step();
      chk("midrst_quiet", {MOVE, LOAD, DONE}, 0);
    end
    run_cmd(1'b0, 2, 1'b1, 2, 0, od, oe, osd);

    // randomized commands against the model
    for (int i = 0; i < 60; i++) begin
      logic r_op, r_dir;
      int   r_lane, r_steps, r_oor;
      r_op    = ($urandom_range(0, 4) == 0);
      r_lane  = $urandom_range(0, LANES);
      r_dir   = 1'($urandom);
      r_steps = $urandom_range(0, 6);
      r_oor   = ($urandom_range(0, 2) == 0) ? $urandom_range(1, r_steps + 1) : 0;
      run_cmd(r_op, r_lane, r_dir, r_steps, r_oor, od, oe, osd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
